// File: rtl/axi_slv_rd_if.sv
// AR/R channel bundle between an AXI read master and the axi_slv_rd responder.
// The slave modport is the responder side; the master modport drives requests and accepts beats.
interface axi_slv_rd_if #(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32
);
  logic [AXI_ID_WIDTH-1:0]   axi_slv_arid;
  logic [AXI_ADDR_WIDTH-1:0] axi_slv_araddr;
  logic [7:0]                axi_slv_arlen;
  logic                      axi_slv_arvalid;
  logic                      axi_slv_arready;
  logic [AXI_ID_WIDTH-1:0]   axi_slv_rid;
  logic [DATA_WIDTH-1:0]     axi_slv_rdata;
  logic [1:0]                axi_slv_rresp;
  logic                      axi_slv_rlast;
  logic                      axi_slv_rvalid;
  logic                      axi_slv_rready;

  modport slave (
    input  axi_slv_arid, axi_slv_araddr, axi_slv_arlen, axi_slv_arvalid, axi_slv_rready,
    output axi_slv_arready, axi_slv_rid, axi_slv_rdata, axi_slv_rresp, axi_slv_rlast,
           axi_slv_rvalid
  );

  modport master (
    output axi_slv_arid, axi_slv_araddr, axi_slv_arlen, axi_slv_arvalid, axi_slv_rready,
    input  axi_slv_arready, axi_slv_rid, axi_slv_rdata, axi_slv_rresp, axi_slv_rlast,
           axi_slv_rvalid
  );
endinterface

// File: rtl/axi_slv_rd.sv
// AXI read responder: queues AR requests and returns beats whose data is the beat address.
// Define AXI_SLV_RD_BURST_EN to honour arlen (INCR bursts); otherwise every request is one beat.
module axi_slv_rd #(
  parameter int                        AXI_ID_WIDTH   = 4,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        DATA_WIDTH     = 32,
  parameter int                        OSTD_DEPTH     = 4,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_LIMIT     = 'h1000
) (
  input logic         clk,
  input logic         rst_n,
  axi_slv_rd_if.slave slv
);
  localparam int PTR_W = $clog2(OSTD_DEPTH);
  localparam int MAX_W = (DATA_WIDTH > AXI_ADDR_WIDTH) ? DATA_WIDTH : AXI_ADDR_WIDTH;

  typedef enum logic {IDLE, BEAT} state_t;

  function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [MAX_W-1:0] ext;
    ext = MAX_W'(a);
    return ext[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [1:0] beat_resp(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a >= ADDR_LIMIT) ? 2'b10 : 2'b00;
  endfunction

  logic [AXI_ID_WIDTH-1:0]   id_q   [OSTD_DEPTH];
  logic [AXI_ADDR_WIDTH-1:0] addr_q [OSTD_DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [PTR_W:0]            count;
  logic                      full, empty, push, pop, hs;
  state_t                    state, state_nxt;
  logic [AXI_ID_WIDTH-1:0]   id_p1;
  logic [AXI_ADDR_WIDTH-1:0] addr_p1;
  logic                      vld_p1, last_p1;

`ifdef AXI_SLV_RD_BURST_EN
  localparam int BYTES = DATA_WIDTH / 8;
  logic [7:0] len_q [OSTD_DEPTH];
  logic [7:0] len_p1, beat_p1;
  assign last_p1 = (beat_p1 == len_p1);
`else
  assign last_p1 = 1'b1;
  wire unused_arlen = &{1'b0, slv.axi_slv_arlen};
`endif

  assign full  = (count == (PTR_W+1)'(OSTD_DEPTH));
  assign empty = (count == '0);
  // arready follows the count only, so a same-cycle pop never raises it early
  assign slv.axi_slv_arready = rst_n && !full;
  assign push = slv.axi_slv_arvalid && slv.axi_slv_arready;
  assign hs   = vld_p1 && slv.axi_slv_rready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Stage p0: request storage
  always_ff @(posedge clk) begin
    if (push) begin
      id_q[wr_ptr]   <= slv.axi_slv_arid;
      addr_q[wr_ptr] <= slv.axi_slv_araddr;
`ifdef AXI_SLV_RD_BURST_EN
      len_q[wr_ptr]  <= slv.axi_slv_arlen;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop       = 1'b1;
        state_nxt = BEAT;
      end
      BEAT: if (slv.axi_slv_rready && last_p1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: active burst, held stable until the beat handshakes
  always_ff @(posedge clk) begin
    if (pop) begin
      id_p1   <= id_q[rd_ptr];
      addr_p1 <= addr_q[rd_ptr];
`ifdef AXI_SLV_RD_BURST_EN
      len_p1  <= len_q[rd_ptr];
      beat_p1 <= '0;
    end else if (hs && !last_p1) begin
      beat_p1 <= beat_p1 + 1'b1;
      addr_p1 <= addr_p1 + AXI_ADDR_WIDTH'(BYTES);
`endif
    end
  end

  // Payload is gated by valid so outputs read zero whenever no beat is offered
  assign vld_p1             = (state == BEAT);
  assign slv.axi_slv_rvalid = vld_p1;
  assign slv.axi_slv_rid    = vld_p1 ? id_p1 : '0;
  assign slv.axi_slv_rdata  = vld_p1 ? beat_data(addr_p1) : '0;
  assign slv.axi_slv_rresp  = vld_p1 ? beat_resp(addr_p1) : 2'b00;
  assign slv.axi_slv_rlast  = vld_p1 && last_p1;
endmodule

// File: tb/tb_axi_slv_rd.sv
// Directed bench for axi_slv_rd: single reads, bursts, backpressure, queue full, SLVERR boundary, reset.
// Expectations follow AXI_SLV_RD_BURST_EN when it is defined for the build.
module tb_axi_slv_rd;
  localparam int IDW   = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
`ifdef AXI_SLV_RD_BURST_EN
  localparam int BURST = 1;
`else
  localparam int BURST = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  axi_slv_rd_if #(.AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  axi_slv_rd #(
    .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .OSTD_DEPTH(DEPTH), .ADDR_LIMIT(32'h1000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .slv(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbeats(input int len);
    return (BURST != 0) ? len + 1 : 1;
  endfunction

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n;
    n = 0;
    bus.axi_slv_arid    = id;
    bus.axi_slv_araddr  = addr;
    bus.axi_slv_arlen   = len;
    bus.axi_slv_arvalid = 1'b1;
    while (!bus.axi_slv_arready && n < 50) begin
      tick();
      n++;
    end
    chk("ar_accept", 64'(bus.axi_slv_arready), 64'd1);
    tick();
    bus.axi_slv_arvalid = 1'b0;
  endtask

  task automatic wait_rvalid(output int waited);
    waited = 0;
    while (!bus.axi_slv_rvalid && waited < 50) begin
      tick();
      waited++;
    end
  endtask

  // err_mask bit i set means beat i must report SLVERR
  task automatic take_burst(input string tag, input logic [3:0] id, input logic [31:0] addr,
                            input int nb, input logic [7:0] err_mask);
    int w;
    bus.axi_slv_rready = 1'b1;
    for (int i = 0; i < nb; i++) begin
      wait_rvalid(w);
      if (i > 0) chk({tag, "_gap"}, 64'(w), 64'd0);
      chk({tag, "_vld"},  64'(bus.axi_slv_rvalid), 64'd1);
      chk({tag, "_id"},   64'(bus.axi_slv_rid), 64'(id));
      chk({tag, "_data"}, 64'(bus.axi_slv_rdata), 64'(addr + 32'(4 * i)));
      chk({tag, "_resp"}, 64'(bus.axi_slv_rresp), err_mask[i] ? 64'd2 : 64'd0);
      chk({tag, "_last"}, 64'(bus.axi_slv_rlast), 64'(i == nb - 1));
      tick();
    end
    bus.axi_slv_rready = 1'b0;
    chk({tag, "_bubble"}, 64'(bus.axi_slv_rvalid), 64'd0);
  endtask

  initial begin
    int acc, w, i, cyc, nb, seen;
    bus.axi_slv_arid    = '0;
    bus.axi_slv_araddr  = '0;
    bus.axi_slv_arlen   = '0;
    bus.axi_slv_arvalid = 1'b0;
    bus.axi_slv_rready  = 1'b0;
    repeat (3) tick();

    chk("rst_arready", 64'(bus.axi_slv_arready), 64'd0);
    chk("rst_rvalid",  64'(bus.axi_slv_rvalid), 64'd0);
    chk("rst_rlast",   64'(bus.axi_slv_rlast), 64'd0);
    chk("rst_rid",     64'(bus.axi_slv_rid), 64'd0);
    chk("rst_rdata",   64'(bus.axi_slv_rdata), 64'd0);
    chk("rst_rresp",   64'(bus.axi_slv_rresp), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_arready", 64'(bus.axi_slv_arready), 64'd1);

    // single read and its two-cycle latency
    send_ar(4'd3, 32'h40, 8'd0);
    chk("lat_n1", 64'(bus.axi_slv_rvalid), 64'd0);
    tick();
    chk("lat_n2", 64'(bus.axi_slv_rvalid), 64'd1);
    take_burst("single", 4'd3, 32'h40, 1, 8'h00);

    send_ar(4'd5, 32'h100, 8'd3);
    take_burst("burst", 4'd5, 32'h100, nbeats(3), 8'h00);

    // random backpressure: a stalled beat is rechecked against the same expectation
    send_ar(4'd7, 32'h200, 8'd7);
    nb = nbeats(7);
    i = 0;
    cyc = 0;
    while (i < nb && cyc < 400) begin
      bus.axi_slv_rready = 1'($urandom_range(0, 1));
      if (bus.axi_slv_rvalid) begin
        chk("bp_id",   64'(bus.axi_slv_rid), 64'd7);
        chk("bp_data", 64'(bus.axi_slv_rdata), 64'(32'h200 + 32'(4 * i)));
        chk("bp_last", 64'(bus.axi_slv_rlast), 64'(i == nb - 1));
        if (bus.axi_slv_rready) i++;
      end
      tick();
      cyc++;
    end
    bus.axi_slv_rready = 1'b0;
    chk("bp_count", 64'(i), 64'(nb));
    chk("bp_after", 64'(bus.axi_slv_rvalid), 64'd0);

    send_ar(4'd9, 32'hFF8, 8'd3);
    take_burst("err_cross", 4'd9, 32'hFF8, nbeats(3), 8'b0000_1100);
    send_ar(4'd10, 32'h1000, 8'd0);
    take_burst("err_at", 4'd10, 32'h1000, 1, 8'h01);
    send_ar(4'd11, 32'hFFC, 8'd0);
    take_burst("err_below", 4'd11, 32'hFFC, 1, 8'h00);

    // queue full: engine holds one burst, queue holds DEPTH more
    acc = 0;
    bus.axi_slv_arvalid = 1'b1;
    bus.axi_slv_arlen   = 8'd0;
    for (int c = 0; c < 10; c++) begin
      bus.axi_slv_arid   = 4'(acc + 1);
      bus.axi_slv_araddr = 32'h300 + 32'(acc * 16);
      if (bus.axi_slv_arready) acc++;
      tick();
    end
    chk("full_accepts", 64'(acc), 64'(DEPTH + 1));
    chk("full_arready", 64'(bus.axi_slv_arready), 64'd0);
    chk("full_rid",     64'(bus.axi_slv_rid), 64'd1);
    bus.axi_slv_rready = 1'b1;
    tick();
    bus.axi_slv_rready = 1'b0;
    chk("full_pulse_arready", 64'(bus.axi_slv_arready), 64'd0);
    chk("full_pulse_bubble",  64'(bus.axi_slv_rvalid), 64'd0);
    tick();
    chk("full_freed_arready", 64'(bus.axi_slv_arready), 64'd1);
    chk("full_next_rid",      64'(bus.axi_slv_rid), 64'd2);
    tick();
    bus.axi_slv_arvalid = 1'b0;
    for (int k = 2; k <= 6; k++)
      take_burst("drain", 4'(k), 32'h300 + 32'((k - 1) * 16), 1, 8'h00);

    // reset mid-burst (beat 2 when bursts are enabled)
    send_ar(4'd4, 32'h500, 8'd7);
    wait_rvalid(w);
`ifdef AXI_SLV_RD_BURST_EN
    bus.axi_slv_rready = 1'b1;
    tick();
    tick();
    bus.axi_slv_rready = 1'b0;
`endif
    chk("rst_mid_data", 64'(bus.axi_slv_rdata), 64'(32'h500 + 32'(8 * BURST)));
    bus.axi_slv_arid    = 4'd12;
    bus.axi_slv_araddr  = 32'h600;
    bus.axi_slv_arlen   = 8'd0;
    bus.axi_slv_arvalid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_arready_now", 64'(bus.axi_slv_arready), 64'd0);
    tick();
    chk("rst_mid_rvalid",  64'(bus.axi_slv_rvalid), 64'd0);
    chk("rst_mid_arready", 64'(bus.axi_slv_arready), 64'd0);
    chk("rst_mid_rlast",   64'(bus.axi_slv_rlast), 64'd0);
    rst_n = 1'b1;
    bus.axi_slv_arvalid = 1'b0;
    bus.axi_slv_rready  = 1'b1;
    #1;
    chk("rst_rel_arready", 64'(bus.axi_slv_arready), 64'd1);
    seen = 0;
    repeat (10) begin
      tick();
      if (bus.axi_slv_rvalid) seen++;
    end
    chk("rst_no_stale", 64'(seen), 64'd0);
    bus.axi_slv_rready = 1'b0;

    send_ar(4'd13, 32'h80, 8'd0);
    take_burst("post_rst", 4'd13, 32'h80, 1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
